bic_receive: RTL

- Serial character receiver; the receive-side counterpart of the bit-counter transmitter on the chat link.
- Oversamples the incoming line at OVERSAMPLE clocks per bit, using a bit-sampling counter (BSC) and a bit-identifying counter (BIC).
- Frame format: start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
- Delivers each received character as a parallel word with a one-cycle strobe to the chat display/buffer logic.

---
 rtl/bic_receive_if.sv | 30 +++
 rtl/bic_receive.sv | 133 +++++++++++++
 2 files changed

// File: rtl/bic_receive_if.sv
// Receive-side bundle for the chat link: serial line and enable in,
// received character, status strobes and busy flag out.
interface bic_receive_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 serialIn;
  logic                 recEn;
  logic [DATA_BITS-1:0] dataOut;
  logic                 charReceived;
  logic                 frameError;
  logic                 busy;

  modport master (
    output serialIn,
    output recEn,
    input  dataOut,
    input  charReceived,
    input  frameError,
    input  busy
  );

  modport slave (
    input  serialIn,
    input  recEn,
    output dataOut,
    output charReceived,
    output frameError,
    output busy
  );
endinterface

// File: rtl/bic_receive.sv
// Oversampling serial character receiver: start/data/stop framing tracked by a
// bit-sampling counter (bsc) and a bit-identifying counter (bic).
module bic_receive #(
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned SAMPLE_POINT = 7
) (
  input  logic         srClock,
  input  logic         rst,
  bic_receive_if.slave bus
);

  localparam int unsigned BSCW = $clog2(OVERSAMPLE);
  localparam int unsigned BICW = $clog2(DATA_BITS + 1);

  localparam logic [BSCW-1:0] BSC_SAMPLE = BSCW'(SAMPLE_POINT);
  localparam logic [BSCW-1:0] BSC_LAST   = BSCW'(OVERSAMPLE - 1);
  localparam logic [BICW-1:0] BIC_LAST   = BICW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 syncIn;
  logic [BSCW-1:0]      bsc;
  logic [BICW-1:0]      bic;
  logic [DATA_BITS-1:0] shreg;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge srClock or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      syncIn <= 1'b1;
    end else begin
      sync1  <= bus.serialIn;
      syncIn <= sync1;
    end
  end

  always_ff @(posedge srClock or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bsc              <= '0;
      bic              <= '0;
      shreg            <= '0;
      bus.dataOut      <= '0;
      bus.charReceived <= 1'b0;
      bus.frameError   <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.charReceived <= 1'b0;
      bus.frameError   <= 1'b0;

      unique case (state)
        IDLE: begin
          bsc <= '0;
          bic <= '0;
          if (bus.recEn && !syncIn) begin
            state    <= START;
            bus.busy <= 1'b1;
          end
        end

        START: begin
          if (bsc == BSC_SAMPLE) begin
            bsc <= '0;
            bic <= '0;
            if (!syncIn) begin
              state <= DATA;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else begin
            bsc <= bsc + 1'b1;
          end
        end

        // bsc wraps naturally because OVERSAMPLE is a power of two.
        DATA: begin
          bsc <= bsc + 1'b1;
          if (bsc == BSC_LAST) begin
            shreg <= {syncIn, shreg[DATA_BITS-1:1]};
            bic   <= bic + 1'b1;
            if (bic == BIC_LAST) begin
              state <= STOP;
            end
          end
        end

        STOP: begin
          bsc <= bsc + 1'b1;
          if (bsc == BSC_LAST) begin
            bic <= '0;
            if (syncIn) begin
              bus.dataOut      <= shreg;
              bus.charReceived <= 1'b1;
              state            <= IDLE;
              bus.busy         <= 1'b0;
            end else begin
              bus.frameError <= 1'b1;
              state          <= WAIT_HIGH;
            end
          end
        end

        // A break or stuck-low line must not retrigger frames.
        WAIT_HIGH: begin
          bsc <= '0;
          bic <= '0;
          if (syncIn) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bsc      <= '0;
          bic      <= '0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
